// File: rtl/mem_stage_pkg.sv
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam int unsigned MEM_BRANCH = 2;
  localparam int unsigned MEM_READ   = 1;
  localparam int unsigned MEM_WRITE  = 0;

endpackage

// File: rtl/mem_wb_reg.sv
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        bubble,
  input  logic [1:0]  wbControl,
  input  logic [31:0] readData,
  input  logic [31:0] aluResult,
  input  logic [4:0]  writeRegister,
  output logic [1:0]  wbControlMemWb,
  output logic [31:0] readDataMemWb,
  output logic [31:0] aluResultMemWb,
  output logic [4:0]  writeRegisterMemWb
);

  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      wbControlMemWb     <= '0;
      readDataMemWb      <= '0;
      aluResultMemWb     <= '0;
      writeRegisterMemWb <= '0;
    end else begin
      wbControlMemWb     <= wbControl;
      readDataMemWb      <= readData;
      aluResultMemWb     <= aluResult;
      writeRegisterMemWb <= writeRegister;
    end
  end

endmodule

// File: rtl/mem_stage_wb.sv
module mem_stage_wb
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  branch,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [1:0]            wbControlExMem,
  input  logic [31:0]           aluResult,
  input  logic                  aluZero,
  input  logic [31:0]           pc,
  input  logic [31:0]           registerData,
  input  logic [4:0]            writeRegister,
  output logic                  dmemReq,
  output logic                  dmemWe,
  output logic [ADDR_WIDTH-1:0] dmemAddr,
  output logic [31:0]           dmemWdata,
  input  logic                  dmemAck,
  input  logic [31:0]           dmemRdata,
  output logic                  stall,
  output logic                  pcSrc,
  output logic [31:0]           branchTarget,
  output logic                  memError,
  output logic [1:0]            wbControlMemWb,
  output logic [31:0]           readDataMemWb,
  output logic [31:0]           aluResultMemWb,
  output logic [4:0]            writeRegisterMemWb
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic [2:0]  memCtl;
  logic        access;
  logic        ackRead;
  logic [31:0] readData;

  assign memCtl = {branch, memRead, memWrite};
  assign access = memCtl[MEM_READ] | memCtl[MEM_WRITE];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    stall   = 1'b0;
    ackRead = 1'b0;
    case (state_q)
      IDLE: begin
        stall = access;
        if (access) begin
          state_d = REQ;
          cnt_d   = '0;
          addr_d  = aluResult[ADDR_WIDTH-1:0];
          we_d    = memCtl[MEM_WRITE];
          wdata_d = registerData;
        end
      end
      REQ: begin
        // ack takes priority over a coincident timeout
        if (dmemAck) begin
          state_d = IDLE;
          ackRead = ~we_q;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign dmemReq      = (state_q == REQ);
  assign dmemWe       = we_q;
  assign dmemAddr     = addr_q;
  assign dmemWdata    = wdata_q;
  assign memError     = err_q;
  assign pcSrc        = memCtl[MEM_BRANCH] & aluZero;
  assign branchTarget = pc;
  assign readData     = ackRead ? dmemRdata : '0;

  mem_wb_reg u_mem_wb (
    .clock              (clock),
    .reset              (reset),
    .bubble             (stall),
    .wbControl          (wbControlExMem),
    .readData           (readData),
    .aluResult          (aluResult),
    .writeRegister      (writeRegister),
    .wbControlMemWb     (wbControlMemWb),
    .readDataMemWb      (readDataMemWb),
    .aluResultMemWb     (aluResultMemWb),
    .writeRegisterMemWb (writeRegisterMemWb)
  );

endmodule

// File: tb/tb_mem_stage_wb.sv
module tb_mem_stage_wb;

  logic        clock = 1'b0;
  logic        reset;
  logic        branch, memRead, memWrite, aluZero, dmemAck;
  logic [1:0]  wbControlExMem;
  logic [31:0] aluResult, pc, registerData, dmemRdata;
  logic [4:0]  writeRegister;
  logic        dmemReq, dmemWe, stall, pcSrc, memError;
  logic [31:0] dmemAddr, dmemWdata, branchTarget;
  logic [1:0]  wbControlMemWb;
  logic [31:0] readDataMemWb, aluResultMemWb;
  logic [4:0]  writeRegisterMemWb;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } wb_t;

  wb_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  always #5 clock = ~clock;

  mem_stage_wb #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .branch             (branch),
    .memRead            (memRead),
    .memWrite           (memWrite),
    .wbControlExMem     (wbControlExMem),
    .aluResult          (aluResult),
    .aluZero            (aluZero),
    .pc                 (pc),
    .registerData       (registerData),
    .writeRegister      (writeRegister),
    .dmemReq            (dmemReq),
    .dmemWe             (dmemWe),
    .dmemAddr           (dmemAddr),
    .dmemWdata          (dmemWdata),
    .dmemAck            (dmemAck),
    .dmemRdata          (dmemRdata),
    .stall              (stall),
    .pcSrc              (pcSrc),
    .branchTarget       (branchTarget),
    .memError           (memError),
    .wbControlMemWb     (wbControlMemWb),
    .readDataMemWb      (readDataMemWb),
    .aluResultMemWb     (aluResultMemWb),
    .writeRegisterMemWb (writeRegisterMemWb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ex();
    branch = 1'b0; memRead = 1'b0; memWrite = 1'b0; aluZero = 1'b0;
    wbControlExMem = '0; aluResult = '0; pc = '0; registerData = '0;
    writeRegister = '0; dmemAck = 1'b0; dmemRdata = '0;
  endtask

  // Write-back monitor: every non-bubble MEM/WB entry must match the next expectation.
  initial begin
    wb_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && wbControlMemWb !== 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("mwb_unexpected", 32'(wbControlMemWb), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("mwb_wb",  32'(wbControlMemWb),     32'(e.wb));
          chk("mwb_rd",  readDataMemWb,           e.rd);
          chk("mwb_alu", aluResultMemWb,          e.alu);
          chk("mwb_wr",  32'(writeRegisterMemWb), 32'(e.wr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_ex();
    tick(); tick();
    @(negedge clock);
    chk("rst_req",   32'(dmemReq), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err",   32'(memError), 32'd0);
    chk("rst_wb",    32'(wbControlMemWb), 32'd0);
    chk("rst_rd",    readDataMemWb, 32'd0);
    chk("rst_alu",   aluResultMemWb, 32'd0);
    chk("rst_wr",    32'(writeRegisterMemWb), 32'd0);
    tick();
    reset = 1'b0;

    // ALU op
    wbControlExMem = 2'b10; aluResult = 32'h1234; writeRegister = 5'd5;
    exp_q.push_back({2'b10, 32'h0, 32'h1234, 5'd5});
    @(negedge clock);
    chk("alu_stall", 32'(stall), 32'd0);
    tick();
    clear_ex();
    @(negedge clock);
    chk("alu_stall2", 32'(stall), 32'd0);

    // Load, ack on third REQ cycle
    tick();
    memRead = 1'b1; aluResult = 32'h40; wbControlExMem = 2'b11; writeRegister = 5'd7;
    exp_q.push_back({2'b11, 32'hDEADBEEF, 32'h40, 5'd7});
    @(negedge clock);
    chk("ld_idle_stall", 32'(stall), 32'd1);
    chk("ld_idle_req",   32'(dmemReq), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin dmemAck = 1'b1; dmemRdata = 32'hDEADBEEF; end
      @(negedge clock);
      chk("ld_req",   32'(dmemReq), 32'd1);
      chk("ld_addr",  dmemAddr, 32'h40);
      chk("ld_we",    32'(dmemWe), 32'd0);
      chk("ld_stall", 32'(stall), (i == 2) ? 32'd0 : 32'd1);
    end
    tick();
    clear_ex();
    @(negedge clock);
    chk("ld_done_req", 32'(dmemReq), 32'd0);

    // Store, immediate ack; EX/MEM inputs perturbed to prove capture
    tick();
    memWrite = 1'b1; registerData = 32'hCAFEF00D; aluResult = 32'h80;
    @(negedge clock);
    chk("st_idle_stall", 32'(stall), 32'd1);
    tick();
    dmemAck = 1'b1; aluResult = 32'h99; registerData = 32'h0;
    @(negedge clock);
    chk("st_req",   32'(dmemReq), 32'd1);
    chk("st_we",    32'(dmemWe), 32'd1);
    chk("st_addr",  dmemAddr, 32'h80);
    chk("st_wdata", dmemWdata, 32'hCAFEF00D);
    chk("st_stall", 32'(stall), 32'd0);
    tick();
    clear_ex();
    @(negedge clock);
    chk("st_done_req", 32'(dmemReq), 32'd0);
    chk("st_err",      32'(memError), 32'd0);

    // Read and write both set: behaves as a write, no load data
    tick();
    memRead = 1'b1; memWrite = 1'b1; aluResult = 32'h84; registerData = 32'h55;
    wbControlExMem = 2'b10; writeRegister = 5'd3;
    exp_q.push_back({2'b10, 32'h0, 32'h84, 5'd3});
    @(negedge clock);
    chk("rw_stall", 32'(stall), 32'd1);
    tick();
    dmemAck = 1'b1; dmemRdata = 32'hFFFFFFFF;
    @(negedge clock);
    chk("rw_we",    32'(dmemWe), 32'd1);
    chk("rw_stall2", 32'(stall), 32'd0);
    tick();
    clear_ex();
    @(negedge clock);

    // Ack on the last (timeout) REQ cycle: ack wins
    tick();
    memRead = 1'b1; aluResult = 32'h48; wbControlExMem = 2'b11; writeRegister = 5'd10;
    exp_q.push_back({2'b11, 32'h11112222, 32'h48, 5'd10});
    @(negedge clock);
    chk("ack4_idle_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin dmemAck = 1'b1; dmemRdata = 32'h11112222; end
      @(negedge clock);
      chk("ack4_req",   32'(dmemReq), 32'd1);
      chk("ack4_stall", 32'(stall), (i == 3) ? 32'd0 : 32'd1);
    end
    tick();
    clear_ex();
    @(negedge clock);
    chk("ack4_err", 32'(memError), 32'd0);
    chk("ack4_req_low", 32'(dmemReq), 32'd0);

    // Timeout with no ack
    tick();
    memRead = 1'b1; aluResult = 32'h44; wbControlExMem = 2'b11; writeRegister = 5'd9;
    exp_q.push_back({2'b11, 32'h0, 32'h44, 5'd9});
    @(negedge clock);
    chk("to_idle_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clock);
      chk("to_req",   32'(dmemReq), 32'd1);
      chk("to_stall", 32'(stall), (i == 3) ? 32'd0 : 32'd1);
      chk("to_err_pre", 32'(memError), 32'd0);
    end
    tick();
    clear_ex();
    @(negedge clock);
    chk("to_req_low", 32'(dmemReq), 32'd0);
    chk("to_err",     32'(memError), 32'd1);
    tick();
    @(negedge clock);
    chk("to_err_sticky", 32'(memError), 32'd1);

    // Branch resolution
    tick();
    branch = 1'b1; aluZero = 1'b1; pc = 32'h100;
    @(negedge clock);
    chk("br_taken",  32'(pcSrc), 32'd1);
    chk("br_target", branchTarget, 32'h100);
    chk("br_stall",  32'(stall), 32'd0);
    tick();
    aluZero = 1'b0; pc = 32'h200;
    @(negedge clock);
    chk("br_not_taken", 32'(pcSrc), 32'd0);
    chk("br_target2",   branchTarget, 32'h200);
    tick();
    clear_ex();

    // Reset during the second REQ cycle of a load
    memRead = 1'b1; aluResult = 32'h4C; wbControlExMem = 2'b11; writeRegister = 5'd12;
    @(negedge clock);
    chk("rr_idle_stall", 32'(stall), 32'd1);
    tick();
    @(negedge clock);
    chk("rr_req1", 32'(dmemReq), 32'd1);
    tick();
    reset = 1'b1;
    clear_ex();
    @(negedge clock);
    tick();
    reset = 1'b0; dmemAck = 1'b1; dmemRdata = 32'hBADBAD00;
    @(negedge clock);
    chk("rr_req",   32'(dmemReq), 32'd0);
    chk("rr_stall", 32'(stall), 32'd0);
    chk("rr_err",   32'(memError), 32'd0);
    chk("rr_wb",    32'(wbControlMemWb), 32'd0);
    chk("rr_rd",    readDataMemWb, 32'd0);
    chk("rr_alu",   aluResultMemWb, 32'd0);
    chk("rr_wr",    32'(writeRegisterMemWb), 32'd0);
    tick();
    dmemAck = 1'b0;
    @(negedge clock);
    chk("rr_late_req", 32'(dmemReq), 32'd0);
    chk("rr_late_rd",  readDataMemWb, 32'd0);
    tick();
    @(negedge clock);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
